// File: rtl/display_serial_receiver_pkg.sv
// display_serial_receiver_pkg: shared states, error codes and frame constants for the display link receiver.
package display_serial_receiver_pkg;
    localparam int FRAME_BITS_DEF = 16;
    localparam logic [3:0] BCD_MAX = 4'd9;
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_LATCH} state_t;
    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_COUNT   = 2'b01,
        ERR_BCD     = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;
endpackage

// File: rtl/display_serial_receiver_if.sv
// display_serial_receiver_if: serial display link pins plus the decoded word and status it produces.
interface display_serial_receiver_if #(
    parameter int FRAME_BITS = 16
);
    logic                  value_signal;
    logic                  data_clock_signal;
    logic                  enable_signal;
    logic                  board_clock_signal;
    logic [FRAME_BITS-1:0] value_bcd;
    logic                  value_valid;
    logic                  frame_error;
    logic [1:0]            error_code;
    modport master (
        output value_signal, data_clock_signal, enable_signal, board_clock_signal,
        input  value_bcd, value_valid, frame_error, error_code
    );
    modport slave (
        input  value_signal, data_clock_signal, enable_signal, board_clock_signal,
        output value_bcd, value_valid, frame_error, error_code
    );
endinterface

// File: rtl/display_serial_receiver_sync_edge.sv
// display_serial_receiver_sync_edge: multi-flop synchronizer with registered level and rise/fall pulses.
module display_serial_receiver_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_in,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    // level_q doubles as the edge-detect history, so level and pulses share one alignment
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
    end
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/display_serial_receiver.sv
// display_serial_receiver: deserializes the display link and publishes only validated BCD words.
module display_serial_receiver
    import display_serial_receiver_pkg::*;
#(
    parameter int FRAME_BITS     = FRAME_BITS_DEF,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic clk,
    input logic reset_in,
    display_serial_receiver_if.slave link
);
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [3:0] pins, level, rise, fall;
    logic unused_sync;
    logic dclk_rise, en_rise, en_fall, latch_rise, bit_in, timeout, bad_bcd;
    state_t state_q, state_d;
    err_t ecode_q, ecode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, bcd_q, bcd_d;
    logic valid_q, valid_d, ferr_q, ferr_d;
    assign pins = {link.board_clock_signal, link.enable_signal, link.data_clock_signal, link.value_signal};
    for (genvar g = 0; g < 4; g++) begin : g_sync
        display_serial_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk(clk), .reset_in(reset_in), .pin(pins[g]),
            .level(level[g]), .rise(rise[g]), .fall(fall[g])
        );
    end
    assign bit_in      = level[0];
    assign dclk_rise   = rise[1];
    assign en_rise     = rise[2];
    assign en_fall     = fall[2];
    assign latch_rise  = rise[3];
    assign unused_sync = ^{level[3:1], rise[0], fall[3], fall[1:0]};
    always_comb begin
        bad_bcd = 1'b0;
        for (int i = 0; i < FRAME_BITS / 4; i++) bad_bcd = bad_bcd | (shift_q[4*i +: 4] > BCD_MAX);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        tmr_d   = tmr_q;
        bcd_d   = bcd_q;
        ecode_d = ecode_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        timeout = !dclk_rise && tmr_q == TW'(TIMEOUT_CYCLES - 1);
        if (state_q != IDLE) tmr_d = dclk_rise ? '0 : tmr_q + TW'(1);
        case (state_q)
            IDLE: if (en_rise) begin
                state_d = SHIFT;
                cnt_d   = '0;
                shift_d = '0;
                tmr_d   = '0;
            end
            SHIFT: begin
                // a bit arriving with the enable fall is still taken before leaving
                if (dclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], bit_in};
                    cnt_d   = cnt_q == CW'(FRAME_BITS + 1) ? cnt_q : cnt_q + CW'(1);
                end
                if (en_fall) state_d = WAIT_LATCH;
                else if (timeout) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                end
            end
            WAIT_LATCH: begin
                if (en_rise) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                    tmr_d   = '0;
                end else if (latch_rise) begin
                    state_d = IDLE;
                    if (cnt_q != CW'(FRAME_BITS)) begin
                        ferr_d  = 1'b1;
                        ecode_d = ERR_COUNT;
                    end else if (bad_bcd) begin
                        ferr_d  = 1'b1;
                        ecode_d = ERR_BCD;
                    end else begin
                        bcd_d   = shift_q;
                        valid_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                    ecode_d = ERR_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            tmr_q   <= '0;
            bcd_q   <= '0;
            ecode_q <= ERR_NONE;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            tmr_q   <= tmr_d;
            bcd_q   <= bcd_d;
            ecode_q <= ecode_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end
    assign link.value_bcd   = bcd_q;
    assign link.value_valid = valid_q;
    assign link.frame_error = ferr_q;
    assign link.error_code  = ecode_q;
endmodule

// File: tb/tb_display_serial_receiver.sv
// tb_display_serial_receiver: table, directed and random frames against a frame-level outcome model.
module tb_display_serial_receiver;
    import display_serial_receiver_pkg::*;
    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          ev;
        int          ee;
        logic [1:0]  code;
        logic [15:0] bcd;
    } vec_t;
    logic clk = 1'b0;
    logic reset_in;
    int n_pass = 0, n_checks = 0;
    int n_valid = 0, n_err = 0, n_both = 0;
    logic [15:0] exp_bcd;
    logic [1:0] exp_code;
    display_serial_receiver_if #(.FRAME_BITS(16)) link();
    display_serial_receiver dut (.clk(clk), .reset_in(reset_in), .link(link));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (link.value_valid) n_valid++;
        if (link.frame_error) n_err++;
        if (link.value_valid && link.frame_error) n_both++;
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask
    task automatic drive_bits(input logic [31:0] bits, input int nbits, input int hi, input int lo);
        for (int i = nbits - 1; i >= 0; i--) begin
            link.value_signal = bits[i];
            cyc(lo);
            link.data_clock_signal = 1'b1;
            cyc(hi);
            link.data_clock_signal = 1'b0;
        end
    endtask
    task automatic send_frame(input logic [31:0] bits, input int nbits, input int hi, input int lo, input bit latch);
        link.enable_signal = 1'b1;
        cyc(1);
        drive_bits(bits, nbits, hi, lo);
        cyc(1);
        link.enable_signal = 1'b0;
        cyc(2);
        if (latch) begin
            link.board_clock_signal = 1'b1;
            cyc(2);
            link.board_clock_signal = 1'b0;
            cyc(8);
        end
    endtask
    task automatic check_frame(input string name, input int v0, input int e0, input int b0,
                               input int ev, input int ee, input logic [1:0] code, input logic [15:0] bcd);
        check({name, ".valid_pulses"}, 32'(n_valid - v0), 32'(ev));
        check({name, ".error_pulses"}, 32'(n_err - e0), 32'(ee));
        check({name, ".error_code"}, 32'(link.error_code), 32'(code));
        check({name, ".value_bcd"}, 32'(link.value_bcd), 32'(bcd));
        check({name, ".both_high"}, 32'(n_both - b0), 32'd0);
    endtask
    // outcome derived from the frame rules alone: bit count, then digit range
    task automatic model(input logic [31:0] bits, input int nbits, output int ev, output int ee);
        int bad = 0;
        ev = 0;
        ee = 1;
        if (nbits != 16) exp_code = 2'b01;
        else begin
            for (int d = 0; d < 4; d++) if ((bits >> (4 * d)) % 16 > 9) bad = 1;
            if (bad != 0) exp_code = 2'b10;
            else begin
                ev = 1;
                ee = 0;
                exp_bcd = bits[15:0];
            end
        end
    endtask
    initial begin
        vec_t tbl[9];
        int v0, e0, b0, ev, ee;
        tbl[0] = '{32'h1234, 16, 1, 0, 2'd0, 16'h1234};
        tbl[1] = '{32'h091A, 15, 0, 1, 2'd1, 16'h1234};
        tbl[2] = '{32'h12A4, 16, 0, 1, 2'd2, 16'h1234};
        tbl[3] = '{32'h0001, 16, 1, 0, 2'd2, 16'h0001};
        tbl[4] = '{32'h9999, 16, 1, 0, 2'd2, 16'h9999};
        tbl[5] = '{32'h19999, 17, 0, 1, 2'd1, 16'h9999};
        tbl[6] = '{32'h0000, 16, 1, 0, 2'd1, 16'h0000};
        tbl[7] = '{32'hF000, 16, 0, 1, 2'd2, 16'h0000};
        tbl[8] = '{32'h0987, 16, 1, 0, 2'd2, 16'h0987};
        reset_in = 1'b0;
        link.value_signal = 1'b0;
        link.data_clock_signal = 1'b0;
        link.enable_signal = 1'b0;
        link.board_clock_signal = 1'b0;
        cyc(3);
        check("reset.value_bcd", 32'(link.value_bcd), 32'd0);
        check("reset.value_valid", 32'(link.value_valid), 32'd0);
        check("reset.frame_error", 32'(link.frame_error), 32'd0);
        check("reset.error_code", 32'(link.error_code), 32'd0);
        reset_in = 1'b1;
        cyc(2);
        // commit latency: valid expected exactly on the 4th edge after the latch pin rises
        v0 = n_valid; e0 = n_err;
        send_frame(32'h1234, 16, 2, 2, 1'b0);
        link.board_clock_signal = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("latency.valid_edge%0d", k), 32'(link.value_valid), 32'(k == 4));
            check($sformatf("latency.error_edge%0d", k), 32'(link.frame_error), 32'd0);
        end
        link.board_clock_signal = 1'b0;
        cyc(4);
        check("latency.value_bcd", 32'(link.value_bcd), 32'h1234);
        check("latency.valid_pulses", 32'(n_valid - v0), 32'd1);
        check("latency.error_pulses", 32'(n_err - e0), 32'd0);
        for (int i = 0; i < 9; i++) begin
            v0 = n_valid; e0 = n_err; b0 = n_both;
            send_frame(tbl[i].bits, tbl[i].nbits, 1 + i % 3, 1 + (i + 1) % 3, 1'b1);
            check_frame($sformatf("table%0d", i), v0, e0, b0, tbl[i].ev, tbl[i].ee, tbl[i].code, tbl[i].bcd);
        end
        v0 = n_valid; e0 = n_err;
        link.enable_signal = 1'b1;
        cyc(1);
        drive_bits(32'h15, 5, 1, 1);
        cyc(4200);
        check("timeout.error_pulses", 32'(n_err - e0), 32'd1);
        check("timeout.valid_pulses", 32'(n_valid - v0), 32'd0);
        check("timeout.error_code", 32'(link.error_code), 32'd3);
        check("timeout.state_idle", 32'(dut.state_q), 32'(IDLE));
        check("timeout.value_bcd", 32'(link.value_bcd), 32'h0987);
        link.enable_signal = 1'b0;
        cyc(3);
        v0 = n_valid; e0 = n_err; b0 = n_both;
        send_frame(32'h9876, 16, 1, 2, 1'b1);
        check_frame("after_timeout", v0, e0, b0, 1, 0, 2'd3, 16'h9876);
        v0 = n_valid; e0 = n_err; b0 = n_both;
        link.enable_signal = 1'b1;
        cyc(1);
        drive_bits(32'h55, 8, 1, 1);
        reset_in = 1'b0;
        #1;
        check("midreset.value_bcd", 32'(link.value_bcd), 32'd0);
        check("midreset.error_code", 32'(link.error_code), 32'd0);
        link.enable_signal = 1'b0;
        cyc(3);
        reset_in = 1'b1;
        cyc(2);
        send_frame(32'h0042, 16, 2, 1, 1'b1);
        check_frame("after_reset", v0, e0, b0, 1, 0, 2'd0, 16'h0042);
        v0 = n_valid; e0 = n_err; b0 = n_both;
        link.enable_signal = 1'b1;
        cyc(1);
        drive_bits(32'h1111, 16, 1, 1);
        cyc(1);
        link.enable_signal = 1'b0;
        cyc(3);
        send_frame(32'h2222, 16, 1, 1, 1'b1);
        check_frame("restart", v0, e0, b0, 1, 0, 2'd0, 16'h2222);
        v0 = n_valid; e0 = n_err; b0 = n_both;
        send_frame(32'h0001, 16, 1, 1, 1'b1);
        link.board_clock_signal = 1'b1;
        cyc(3);
        link.board_clock_signal = 1'b0;
        cyc(6);
        send_frame(32'h9999, 16, 1, 1, 1'b1);
        check_frame("back_to_back", v0, e0, b0, 2, 0, 2'd0, 16'h9999);
        exp_bcd = 16'h9999;
        exp_code = 2'd0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] bits;
            int nb, r;
            r = $urandom_range(0, 9);
            nb = r == 0 ? 15 : r == 1 ? 17 : 16;
            bits = 32'($urandom_range(0, 1));
            for (int d = 0; d < 4; d++)
                bits = bits * 16 + ($urandom_range(0, 7) == 0 ? $urandom_range(10, 15) : $urandom_range(0, 9));
            if (nb == 16) bits = bits & 32'hFFFF;
            v0 = n_valid; e0 = n_err; b0 = n_both;
            send_frame(bits, nb, $urandom_range(1, 3), $urandom_range(1, 3), 1'b1);
            model(bits, nb, ev, ee);
            check_frame($sformatf("random%0d", n), v0, e0, b0, ev, ee, exp_code, exp_bcd);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
